// File: rtl/booth_mult_seq.sv
// booth_mult_seq
// Sequential radix-4 Booth multiplier. It retires one Booth digit per clock,
// so a transaction takes DATA_WIDTH/2+1 digit cycles plus one cycle to
// register the product. Each transaction can be signed or unsigned.
// DATA_WIDTH must be even and at least 4.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous, active-low reset
//   i_valid   operand pair offered (accepted only in IDLE while o_ready=1)
//   o_ready   block can accept operands (registered)
//   i_signed  1 = two's-complement operands, 0 = unsigned; sampled with operands
//   i_a       multiplicand
//   i_b       multiplier
//   o_valid   o_c holds a valid product (registered)
//   i_ready   downstream accepts the product (used only in DONE)
//   o_c       2*DATA_WIDTH-bit product (registered; keeps last value after handoff)
module booth_mult_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_signed,
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [2*DATA_WIDTH-1:0] o_c
);

  // Extended operand width. Two extra bits let an unsigned operand be handled
  // as a positive signed number, so both modes use the same digit count.
  localparam int W  = DATA_WIDTH + 2;
  localparam int N  = DATA_WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  logic signed [2*W-1:0]  acc;
  // Multiplicand, pre-shifted by 2 bits per digit so it always carries the
  // 4^k weight of the digit being processed.
  logic signed [2*W-1:0]  a_sh;
  // Extended multiplier with the implicit b[-1]=0 appended at bit 0; shifted
  // right by 2 per digit so the current Booth triplet is always bits [2:0].
  logic        [W:0]      b_sh;
  logic        [CW-1:0]   cnt;

  // Radix-4 Booth recoding of one triplet into a partial product (mod 2^(2W)).
  function automatic logic signed [2*W-1:0] booth_pp(
    input logic        [2:0]     dig,
    input logic signed [2*W-1:0] a
  );
    case (dig)
      3'b001, 3'b010: booth_pp = a;
      3'b011:         booth_pp = a <<< 1;
      3'b100:         booth_pp = -(a <<< 1);
      3'b101, 3'b110: booth_pp = -a;
      default:        booth_pp = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
      o_c     <= '0;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // o_ready is low only right after reset; raise it one edge later.
          if (!o_ready) begin
            o_ready <= 1'b1;
          end else if (i_valid) begin
            a_sh    <= {{(2*W-DATA_WIDTH){i_a[DATA_WIDTH-1] & i_signed}}, i_a};
            b_sh    <= {{2{i_b[DATA_WIDTH-1] & i_signed}}, i_b, 1'b0};
            acc     <= '0;
            cnt     <= '0;
            o_ready <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // All N digits are in the accumulator once cnt reaches N; the extra
          // cycle registers the product, giving a fixed N+1 edge latency.
          if (cnt == LAST) begin
            o_c     <= acc[2*DATA_WIDTH-1:0];
            o_valid <= 1'b1;
            state   <= DONE;
          end else begin
            acc  <= acc + booth_pp(b_sh[2:0], a_sh);
            a_sh <= a_sh <<< 2;
            b_sh <= b_sh >> 2;
            cnt  <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
